// File: rtl/cnn_upsampling_pkg.sv
// Shared types, sizing helpers and default frame geometry for the
// nearest-neighbour upsampling controller.
package cnn_upsampling_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  // Index width for a counter that runs 0..n-1; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned in_total(input int unsigned w, h, c);
    return w * h * c;
  endfunction

  function automatic int unsigned out_total(input int unsigned s, w, h, c);
    return s * s * w * h * c;
  endfunction

  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_H     = 8;
  localparam int unsigned DEF_C     = 4;
  localparam int unsigned DEF_SCALE = 4;

  localparam int unsigned IN_TOTAL  = in_total(DEF_W, DEF_H, DEF_C);
  localparam int unsigned OUT_TOTAL = out_total(DEF_SCALE, DEF_W, DEF_H, DEF_C);
  localparam int unsigned CW        = idx_w(DEF_SCALE * DEF_W);
  localparam int unsigned RW        = idx_w(DEF_SCALE * DEF_H);
  localparam int unsigned HW        = idx_w(DEF_C);
  localparam int unsigned ICW       = $clog2(IN_TOTAL + 1);
  localparam int unsigned OCW       = $clog2(OUT_TOTAL + 1);

endpackage

// File: rtl/cnn_upsampling_coord_cnt.sv
// Cascaded column/row/channel counter; wrap flags the beat that closes the
// last channel.
module cnn_upsampling_coord_cnt #(
  parameter int unsigned COLS = 32,
  parameter int unsigned ROWS = 32,
  parameter int unsigned CHS  = 4,
  parameter int unsigned CW   = 5,
  parameter int unsigned RW   = 5,
  parameter int unsigned HW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [HW-1:0] ch,
  output logic          wrap
);

  logic col_last, row_last, ch_last;

  assign col_last = (col == CW'(COLS - 1));
  assign row_last = (row == RW'(ROWS - 1));
  assign ch_last  = (ch  == HW'(CHS - 1));
  assign wrap     = en & col_last & row_last & ch_last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else if (en) begin
      col <= col_last ? '0 : col + CW'(1);
      if (col_last) begin
        row <= row_last ? '0 : row + RW'(1);
        if (row_last) ch <= ch_last ? '0 : ch + HW'(1);
      end
    end
  end

endmodule

// File: rtl/cnn_upsampling_ctrl.sv
// Frame controller for the 4x nearest-neighbour upsampler: flush, admit one
// frame of pixels, tag output beats, report done/overflow/timeout.
module cnn_upsampling_ctrl
  import cnn_upsampling_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH    = 8,
  parameter int unsigned IMAGE_HEIGHT   = 8,
  parameter int unsigned CHANNEL_NUM    = 4,
  parameter int unsigned SCALE          = 4,
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned CW = idx_w(SCALE * IMAGE_WIDTH),
  localparam int unsigned RW = idx_w(SCALE * IMAGE_HEIGHT),
  localparam int unsigned HW = idx_w(CHANNEL_NUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          up_rst,
  output logic          up_valid_in,
  input  logic          up_valid_out,
  output logic [CW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic [HW-1:0] out_ch,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err_overflow,
  output logic          err_timeout
);

  localparam int unsigned IN_T  = in_total(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM);
  localparam int unsigned OUT_T = out_total(SCALE, IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM);
  localparam int unsigned ICW_L = $clog2(IN_T + 1);
  localparam int unsigned OCW_L = $clog2(OUT_T + 1);
  localparam int unsigned FCW   = idx_w(FLUSH_CYCLES);
  localparam int unsigned TCW   = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state, state_nxt;
  logic [FCW-1:0]     flush_cnt;
  logic [ICW_L-1:0]   in_cnt;
  logic [OCW_L-1:0]   out_cnt;
  logic [TCW-1:0]     idle_cnt;
  logic start_acc, in_fire, out_full, count_en, ovf_beat;
  logic coord_wrap, drain_end, timeout_hit;

  assign start_acc   = (state == S_IDLE) & start;
  assign in_ready    = (state == S_LOAD);
  assign up_rst      = (state == S_FLUSH);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign in_fire     = in_valid & in_ready;
  assign up_valid_in = in_fire;
  assign out_full    = (out_cnt == OCW_L'(OUT_T));
  assign count_en    = up_valid_out & ~out_full & ((state == S_LOAD) | (state == S_DRAIN));
  assign ovf_beat    = up_valid_out & (out_full | (state == S_IDLE) | (state == S_FLUSH)
                                                | (state == S_DONE));
  assign out_last    = up_valid_out & (out_cnt == OCW_L'(OUT_T - 1));

  // Exit on the final beat itself so done follows it by exactly one cycle.
  assign drain_end   = out_full | coord_wrap;
  assign timeout_hit = (state == S_DRAIN) & ~drain_end & ~up_valid_out
                     & (idle_cnt == TCW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FLUSH;
      S_FLUSH: if (flush_cnt == FCW'(FLUSH_CYCLES - 1)) state_nxt = S_LOAD;
      S_LOAD:  if (in_fire && in_cnt == ICW_L'(IN_T - 1)) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_end || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      flush_cnt    <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      idle_cnt     <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= (state == S_FLUSH) ? flush_cnt + FCW'(1) : '0;
      idle_cnt  <= (state == S_DRAIN && !up_valid_out) ? idle_cnt + TCW'(1) : '0;
      if (start_acc) begin
        in_cnt       <= '0;
        out_cnt      <= '0;
        err_overflow <= 1'b0;
        err_timeout  <= 1'b0;
      end else begin
        if (in_fire)     in_cnt       <= in_cnt + ICW_L'(1);
        if (count_en)    out_cnt      <= out_cnt + OCW_L'(1);
        if (ovf_beat)    err_overflow <= 1'b1;
        if (timeout_hit) err_timeout  <= 1'b1;
      end
    end
  end

  cnn_upsampling_coord_cnt #(
    .COLS(SCALE * IMAGE_WIDTH),
    .ROWS(SCALE * IMAGE_HEIGHT),
    .CHS (CHANNEL_NUM),
    .CW  (CW),
    .RW  (RW),
    .HW  (HW)
  ) u_coord (
    .clk  (clk),
    .reset(reset),
    .clr  (start_acc),
    .en   (count_en),
    .col  (out_col),
    .row  (out_row),
    .ch   (out_ch),
    .wrap (coord_wrap)
  );

endmodule

// File: doc/cnn_upsampling_ctrl.md
# cnn_upsampling_ctrl

Frame-level controller for the nearest-neighbour 4x upsampling datapath (`cnn_upsampling_nn`). It receives a frame start command and an upstream pixel stream. Per frame it flushes the datapath, admits exactly one frame of input pixels, and counts and tags every upsampled output beat. It reports completion, overflow and timeout to the layer scheduler. It sits between the layer sequencer and the upsampling datapath; pixel data does not pass through it.

## Interface
- IMAGE_WIDTH, 8, input columns per channel
- IMAGE_HEIGHT, 8, input rows per channel
- CHANNEL_NUM, 4, channels per frame
- SCALE, 4, upsampling factor per axis (fixed by the datapath)
- FLUSH_CYCLES, 2, cycles `up_rst` is held at frame start (≥1)
- TIMEOUT_CYCLES, 4096, maximum idle cycles between output beats in DRAIN
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  frame start command; honoured only in IDLE
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  controller accepts an upstream pixel
- up_rst  out  1  synchronous reset to the datapath
- up_valid_in  out  1  datapath write strobe, equal to in_valid & in_ready
- up_valid_out  in  1  datapath output beat valid
- out_col  out  CW  column of the current output beat, range 0..SCALE*IMAGE_WIDTH-1
- out_row  out  RW  row of the current output beat, range 0..SCALE*IMAGE_HEIGHT-1
- out_ch  out  HW  channel of the current output beat
- out_last  out  1  current beat is the final beat of the frame
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse when the frame ends
- err_overflow  out  1  sticky; cleared by reset or an accepted start
- err_timeout  out  1  sticky; cleared by reset or an accepted start

## Operation
- Derived constants: IN_TOTAL = W·H·C and OUT_TOTAL = SCALE²·W·H·C. Counters are sized with clog2(total+1).
- States: IDLE, FLUSH, LOAD, DRAIN, DONE.
- IDLE: in_ready=0, up_rst=0. On `start`, clear all counters and error flags, then go to FLUSH.
- FLUSH: up_rst=1 for exactly FLUSH_CYCLES cycles, then go to LOAD.
- LOAD: in_ready=1. Each in_valid beat increments in_cnt. The beat that makes in_cnt reach IN_TOTAL moves the FSM to DRAIN; in_ready drops in the next cycle.
- DRAIN: in_ready=0. Wait until out_cnt reaches OUT_TOTAL, then go to DONE. If TIMEOUT_CYCLES consecutive cycles pass without up_valid_out, set err_timeout and go to DONE.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Output counting is active in LOAD and DRAIN, because the datapath starts emitting once its first pixel is written. For each up_valid_out:
  - out_col advances.
  - When out_col wraps at SCALE·W-1, out_row advances.
  - When out_row wraps at SCALE·H-1, out_ch advances.
  - out_cnt increments.
- out_col, out_row and out_ch are registered counters. They describe the beat currently presented, so they are valid when up_valid_out=1.
- out_last = up_valid_out & (out_cnt == OUT_TOTAL-1).
- Overflow: up_valid_out in IDLE, FLUSH or DONE, or when out_cnt == OUT_TOTAL, sets err_overflow. Those beats do not advance the counters.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - All counters = 0.
  - in_ready, up_rst, done, out_last, busy, err_overflow, err_timeout = 0.
  - up_valid_in = 0.
  - out_col, out_row, out_ch = 0.
- Reset asserted mid-frame aborts the frame on the next edge. `done` is not pulsed.
- start at cycle t: busy=1 and up_rst=1 at t+1 through t+FLUSH_CYCLES. in_ready=1 at t+FLUSH_CYCLES+1.
- up_valid_in is combinational from in_valid, so there is zero added latency to the datapath.
- The final output beat at cycle t gives DONE at t+1 (done=1) and IDLE at t+2.
- If the final input beat and an output beat occur in the same cycle, both are counted.
- A start pulse arriving in the same cycle as done is ignored.

## Structure
- Package `cnn_upsampling_pkg` holds:
  - the state enum;
  - derived constants IN_TOTAL and OUT_TOTAL;
  - clog2-based widths CW, RW, HW and the counter widths.
- One sub-module, `cnn_upsampling_coord_cnt`: a cascaded column/row/channel counter with an enable input and a wrap output.
- The FSM, flush counter and watchdog stay in the top module.

## Test plan
- W=2, H=2, C=2; start, 8 back-to-back inputs, datapath model emits 128 beats:
  - exactly 8 up_valid_in;
  - out_col runs 0..7 and out_row runs 0..7 per channel, with out_ch 0 then 1;
  - out_last on beat 128;
  - done at the next cycle;
  - no error flags.
- Same configuration with in_valid asserted on alternate cycles:
  - in_ready stays high until the 8th accepted pixel;
  - total output count is unchanged.
- Stray up_valid_out in IDLE: err_overflow=1, counters stay 0. A following start clears the flag.
- Datapath model stops after 100 beats, TIMEOUT_CYCLES=16: err_timeout set 16 cycles after the last beat, then done, then IDLE.
- Reset asserted in the middle of LOAD: all outputs return to reset values on the next edge, and no done pulse is produced.
- start held high during DRAIN and DONE: ignored. Exactly one FLUSH sequence occurs, with FLUSH_CYCLES=2 giving a 2-cycle up_rst.
